dmem_write_checker: RTL and testbench
=====================================

DMEM_WRITE_CHECKER -- requirements
Module: dmem_write_checker

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the data memory write data and of the expected data.
REQ-002 Parameter ADDR_WIDTH, 32, width of the data memory address.
REQ-003 Parameter NUM_CHECKS, 16, number of expected-write table entries; IDX_WIDTH = clog2(NUM_CHECKS).
REQ-004 Parameter IGN_BASE, 96, byte address of the ignored write window.
REQ-005 Parameter IGN_SIZE, 4, number of ignored bytes starting at IGN_BASE; 0 disables the window.
REQ-006 Parameter DONE_ADDR, 40, address of the end-of-test write.
REQ-007 Parameter DONE_DATA, 30, data of the end-of-test write.
REQ-008 Parameter TIMEOUT_CYCLES, 100000, cycles allowed in RUN before a timeout; 0 disables the timeout.
REQ-009 One clock; reset is synchronous and active-high: iclk input 1, rising-edge clock; irst input 1, synchronous active-high reset.
REQ-010 iprog_en, input, 1, writes one table entry this cycle.
REQ-011 iprog_idx, input, IDX_WIDTH, entry index to program.
REQ-012 iprog_addr, input, ADDR_WIDTH, expected address for the entry.
REQ-013 iprog_data, input, DATA_WIDTH, expected data for the entry.
REQ-014 iprog_cnt, input, 1, 1 = the first hit increments the pass count; 0 = the entry is accepted but not counted.
REQ-015 iprog_valid, input, 1, entry enable; 0 clears the entry.
REQ-016 iexp_count, input, IDX_WIDTH+1, minimum pass count required at the end-of-test write.
REQ-017 idmem_wr_en, input, 1, data memory write strobe.
REQ-018 idmem_addr, input, ADDR_WIDTH, data memory write address.
REQ-019 idmem_wr_data, input, DATA_WIDTH, data memory write data.
REQ-020 odone, output, 1, the checker has reached a terminal state.
REQ-021 opass, output, 1, terminal state is PASS.
REQ-022 ofail, output, 1, terminal state is FAIL.
REQ-023 ocause, output, 2, failure cause: 0 none, 1 unexpected write, 2 timeout, 3 count short.
REQ-024 ocount, output, IDX_WIDTH+1, number of distinct counted entries that have been hit.
REQ-025 ohit_mask, output, NUM_CHECKS, sticky per-entry hit flags.
REQ-026 ofail_addr and ofail_data, output, ADDR_WIDTH and DATA_WIDTH, the captured write that caused the failure; both are 0 otherwise.

Function
REQ-027 The FSM has the states RUN, PASS and FAIL; PASS and FAIL are terminal and are left only by irst.
REQ-028 In RUN, a write (idmem_wr_en=1) is classified on the rising edge in this priority order:
  - done: address == DONE_ADDR and data == DONE_DATA.
  - match: the lowest-index valid entry with equal address and data.
  - ignore: IGN_BASE <= address < IGN_BASE+IGN_SIZE.
  - otherwise: unexpected.
REQ-029 On a match, the entry's ohit_mask bit SHALL set; ocount SHALL increment only if the entry has cnt=1 and its hit bit was previously 0.
REQ-030 A repeated hit on the same entry SHALL be accepted with no count change and no failure.
REQ-031 An ignored write SHALL cause no state change.
REQ-032 An unexpected write SHALL move to FAIL with ocause=1 and capture the write into ofail_addr and ofail_data.
REQ-033 On a done write with ocount >= iexp_count, the FSM SHALL move to PASS; otherwise it SHALL move to FAIL with ocause=3 and capture the write.
REQ-034 A cycle counter SHALL run in RUN; when it reaches TIMEOUT_CYCLES with no done write, the FSM SHALL move to FAIL with ocause=2 and ofail_addr/ofail_data = 0.
REQ-035 If a write and the timeout occur in the same cycle, the write classification SHALL take precedence.
REQ-036 All outputs SHALL be registered; a write's effect SHALL be visible the cycle after the sampling edge (1-cycle latency).
REQ-037 Programming SHALL be allowed in any state.
  - A write in the same cycle is checked against the table contents before the update.
  - Programming an entry SHALL clear its hit bit; ocount is not decremented.
REQ-038 In PASS and FAIL, writes and timeout SHALL be ignored; ocount and ohit_mask are frozen.
REQ-039 ocount SHALL saturate at its maximum value; the cycle counter SHALL saturate at TIMEOUT_CYCLES.

Reset
REQ-040 While irst=1 at a rising edge:
  - state = RUN; cycle counter = 0; ocount = 0; ohit_mask = 0.
  - odone = opass = ofail = 0; ocause = 0; ofail_addr = ofail_data = 0.
  - All table entries become invalid.
REQ-041 Reset mid-test, including in PASS or FAIL, SHALL return the block to the full reset state on the next edge; programming is ignored while irst=1.

Verification
REQ-042 Program {100/25 cnt, 104/4096 cnt}, iexp_count=2; write 100/25, 104/4096, 40/30 -> opass=1, ocount=2, ohit_mask=0b11.
REQ-043 Program 100/25 cnt; write 100/25 twice, then 40/30 with iexp_count=1 -> ocount=1, opass=1.
REQ-044 Write 97/x, then 200/7 -> the 97 write is ignored; FAIL, ocause=1, ofail_addr=200, ofail_data=7, one cycle after the 200 write.
REQ-045 iexp_count=3, two counted hits, then write 40/30 -> FAIL, ocause=3, ofail_addr=40.
REQ-046 TIMEOUT_CYCLES=50, no writes -> FAIL, ocause=2 after 50 RUN cycles; a 100/25 write on cycle 50 instead wins.
REQ-047 Assert irst in PASS -> all outputs 0 and table cleared on the next cycle; an unprogrammed 100/25 write then gives ocause=1.

Source files
------------

// File: rtl/dmem_write_checker.sv
// Data-memory write checker: classifies each store of a running test as
// end-of-test, expected (programmable table), ignored or unexpected, and
// reports PASS/FAIL with a cause, hit bookkeeping and the offending write.
module dmem_write_checker #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_CHECKS     = 16,
    parameter int unsigned IGN_BASE       = 96,
    parameter int unsigned IGN_SIZE       = 4,
    parameter int unsigned DONE_ADDR      = 40,
    parameter int unsigned DONE_DATA      = 30,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned IDX_WIDTH     = $clog2(NUM_CHECKS)
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  iprog_en,
    input  logic [IDX_WIDTH-1:0]  iprog_idx,
    input  logic [ADDR_WIDTH-1:0] iprog_addr,
    input  logic [DATA_WIDTH-1:0] iprog_data,
    input  logic                  iprog_cnt,
    input  logic                  iprog_valid,
    input  logic [IDX_WIDTH:0]    iexp_count,
    input  logic                  idmem_wr_en,
    input  logic [ADDR_WIDTH-1:0] idmem_addr,
    input  logic [DATA_WIDTH-1:0] idmem_wr_data,
    output logic                  odone,
    output logic                  opass,
    output logic                  ofail,
    output logic [1:0]            ocause,
    output logic [IDX_WIDTH:0]    ocount,
    output logic [NUM_CHECKS-1:0] ohit_mask,
    output logic [ADDR_WIDTH-1:0] ofail_addr,
    output logic [DATA_WIDTH-1:0] ofail_data
);

    localparam int unsigned CW       = IDX_WIDTH + 1;
    localparam int unsigned AW1      = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam bit          IGN_EN   = (IGN_SIZE != 0);

    localparam logic [CNT_W-1:0]      TMO_SAT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]      TMO_HIT   = CNT_W'(TMO_LAST);
    localparam logic [CW-1:0]         COUNT_MAX = '1;
    localparam logic [AW1-1:0]        IGN_LO    = AW1'(IGN_BASE);
    localparam logic [AW1-1:0]        IGN_HI    = AW1'(64'(IGN_BASE) + 64'(IGN_SIZE));
    localparam logic [ADDR_WIDTH-1:0] END_ADDR  = ADDR_WIDTH'(DONE_ADDR);
    localparam logic [DATA_WIDTH-1:0] END_DATA  = DATA_WIDTH'(DONE_DATA);

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_UNEXP   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_SHORT   = 2'd3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } stateT;

    stateT                 state;
    logic [CNT_W-1:0]      cycleCnt;
    logic [ADDR_WIDTH-1:0] entAddr [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] entData [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] entCnt;
    logic [NUM_CHECKS-1:0] entValid;

    logic                  matchHit;
    logic [IDX_WIDTH-1:0]  matchIdx;
    logic                  isDone;
    logic                  isIgn;
    logic                  tmoNow;

    // Lowest-index valid table entry equal to the current write
    always_comb begin
        matchHit = 1'b0;
        matchIdx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (entValid[i] && (entAddr[i] == idmem_addr) && (entData[i] == idmem_wr_data)) begin
                matchHit = 1'b1;
                matchIdx = IDX_WIDTH'(i);
            end
        end
    end

    assign isDone = (idmem_addr == END_ADDR) && (idmem_wr_data == END_DATA);
    assign isIgn  = IGN_EN && ({1'b0, idmem_addr} >= IGN_LO) && ({1'b0, idmem_addr} < IGN_HI);
    // This edge is the TIMEOUT_CYCLES-th cycle spent in RUN
    assign tmoNow = TMO_EN && (cycleCnt >= TMO_HIT);

    // Checker FSM, outputs and expected-write table
    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= RUN;
            cycleCnt   <= '0;
            ocount     <= '0;
            ohit_mask  <= '0;
            odone      <= 1'b0;
            opass      <= 1'b0;
            ofail      <= 1'b0;
            ocause     <= CAUSE_NONE;
            ofail_addr <= '0;
            ofail_data <= '0;
            entValid   <= '0;
        end else begin
            if (state == RUN) begin
                if (cycleCnt != TMO_SAT) begin
                    cycleCnt <= cycleCnt + CNT_W'(1);
                end
                if (idmem_wr_en) begin
                    if (isDone) begin
                        odone <= 1'b1;
                        if (ocount >= iexp_count) begin
                            state <= PASS;
                            opass <= 1'b1;
                        end else begin
                            state      <= FAIL;
                            ofail      <= 1'b1;
                            ocause     <= CAUSE_SHORT;
                            ofail_addr <= idmem_addr;
                            ofail_data <= idmem_wr_data;
                        end
                    end else if (matchHit) begin
                        ohit_mask[matchIdx] <= 1'b1;
                        if (entCnt[matchIdx] && !ohit_mask[matchIdx] && (ocount != COUNT_MAX)) begin
                            ocount <= ocount + CW'(1);
                        end
                    end else if (!isIgn) begin
                        state      <= FAIL;
                        odone      <= 1'b1;
                        ofail      <= 1'b1;
                        ocause     <= CAUSE_UNEXP;
                        ofail_addr <= idmem_addr;
                        ofail_data <= idmem_wr_data;
                    end
                end else if (tmoNow) begin
                    state      <= FAIL;
                    odone      <= 1'b1;
                    ofail      <= 1'b1;
                    ocause     <= CAUSE_TIMEOUT;
                    ofail_addr <= '0;
                    ofail_data <= '0;
                end
            end
            // Reprogramming overrides a same-cycle hit on that entry; hit flags stay frozen once terminal
            if (iprog_en) begin
                entAddr[iprog_idx]  <= iprog_addr;
                entData[iprog_idx]  <= iprog_data;
                entCnt[iprog_idx]   <= iprog_cnt;
                entValid[iprog_idx] <= iprog_valid;
                if (state == RUN) begin
                    ohit_mask[iprog_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_write_checker.sv
// Bench for dmem_write_checker: directed scenarios plus randomized traffic,
// every output compared each cycle against a behavioural model of the rules.
module tb_dmem_write_checker;

    localparam int TMO = 50;

    logic        clk;
    logic        rst;
    logic        progEn;
    logic [3:0]  progIdx;
    logic [31:0] progAddr;
    logic [31:0] progData;
    logic        progCnt;
    logic        progValid;
    logic [4:0]  expCount;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  cause;
    logic [4:0]  count;
    logic [15:0] hitMask;
    logic [31:0] failAddr;
    logic [31:0] failData;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          mDone, mPass, mFail;
    int          mCause, mCount, mRun;
    logic [15:0] mMask;
    logic [31:0] mFA, mFD;
    logic [31:0] tA [16];
    logic [31:0] tD [16];
    bit          tC [16];
    bit          tV [16];

    logic [31:0] addrPool [6] = '{32'd100, 32'd104, 32'd108, 32'd40, 32'd97, 32'd200};
    logic [31:0] dataPool [6] = '{32'd25, 32'd4096, 32'd7, 32'd30, 32'd0, 32'd1};

    dmem_write_checker #(.TIMEOUT_CYCLES(TMO)) dut (
        .iclk          (clk),
        .irst          (rst),
        .iprog_en      (progEn),
        .iprog_idx     (progIdx),
        .iprog_addr    (progAddr),
        .iprog_data    (progData),
        .iprog_cnt     (progCnt),
        .iprog_valid   (progValid),
        .iexp_count    (expCount),
        .idmem_wr_en   (wrEn),
        .idmem_addr    (wrAddr),
        .idmem_wr_data (wrData),
        .odone         (done),
        .opass         (pass),
        .ofail         (fail),
        .ocause        (cause),
        .ocount        (count),
        .ohit_mask     (hitMask),
        .ofail_addr    (failAddr),
        .ofail_data    (failData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic goFail(input int c, input logic [31:0] a, input logic [31:0] d);
        mDone = 1; mFail = 1; mCause = c; mFA = a; mFD = d;
    endtask

    // Apply the checker rules for the edge that just occurred
    task automatic modelEdge();
        int  hit;
        bit  wasRun;
        if (rst) begin
            mDone = 0; mPass = 0; mFail = 0; mCause = 0; mCount = 0; mRun = 0;
            mMask = '0; mFA = '0; mFD = '0;
            for (int i = 0; i < 16; i++) tV[i] = 0;
            return;
        end
        wasRun = !mDone;
        if (wasRun) begin
            mRun++;
            if (wrEn) begin
                if (wrAddr == 40 && wrData == 30) begin
                    if (mCount >= int'(expCount)) begin
                        mDone = 1; mPass = 1;
                    end else begin
                        goFail(3, wrAddr, wrData);
                    end
                end else begin
                    hit = -1;
                    for (int i = 0; i < 16; i++)
                        if (hit < 0 && tV[i] && tA[i] == wrAddr && tD[i] == wrData) hit = i;
                    if (hit >= 0) begin
                        if (tC[hit] && !mMask[hit]) mCount = (mCount < 31) ? mCount + 1 : 31;
                        mMask[hit] = 1'b1;
                    end else if (!(wrAddr >= 96 && wrAddr < 100)) begin
                        goFail(1, wrAddr, wrData);
                    end
                end
            end else if (mRun >= TMO) begin
                goFail(2, 32'd0, 32'd0);
            end
        end
        if (progEn) begin
            tA[progIdx] = progAddr;
            tD[progIdx] = progData;
            tC[progIdx] = progCnt;
            tV[progIdx] = progValid;
            if (wasRun) mMask[progIdx] = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, " odone"},      64'(done),     64'(mDone));
        chk({tag, " opass"},      64'(pass),     64'(mPass));
        chk({tag, " ofail"},      64'(fail),     64'(mFail));
        chk({tag, " ocause"},     64'(cause),    64'(mCause));
        chk({tag, " ocount"},     64'(count),    64'(mCount));
        chk({tag, " ohit_mask"},  64'(hitMask),  64'(mMask));
        chk({tag, " ofail_addr"}, 64'(failAddr), 64'(mFA));
        chk({tag, " ofail_data"}, 64'(failData), 64'(mFD));
    endtask

    // One clock: inputs are already driven; model and compare 1 time unit after the edge
    task automatic tick(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
        rst = 1'b0; progEn = 1'b0; wrEn = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1; tick("reset");
    endtask

    task automatic setProg(input int i, input logic [31:0] a, input logic [31:0] d, input bit c, input bit v);
        progEn = 1'b1; progIdx = 4'(i); progAddr = a; progData = d; progCnt = c; progValid = v;
    endtask

    task automatic setWr(input logic [31:0] a, input logic [31:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
    endtask

    task automatic prog(input int i, input logic [31:0] a, input logic [31:0] d, input bit c, input bit v);
        setProg(i, a, d, c, v); tick("prog");
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        setWr(a, d); tick("wr");
    endtask

    initial begin
        int r, k;
        rst = 1'b0; progEn = 1'b0; progIdx = '0; progAddr = '0; progData = '0;
        progCnt = 1'b0; progValid = 1'b0; expCount = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0;

        // Reset state
        doReset();
        chk("reset done", 64'(done), 64'd0);
        chk("reset count", 64'(count), 64'd0);

        // Two counted entries then end-of-test
        prog(0, 100, 25, 1, 1);
        prog(1, 104, 4096, 1, 1);
        expCount = 5'd2;
        wr(100, 25);
        wr(104, 4096);
        wr(40, 30);
        chk("basic opass", 64'(pass), 64'd1);
        chk("basic ocount", 64'(count), 64'd2);
        chk("basic mask", 64'(hitMask), 64'h3);

        // Repeated hit counts once
        doReset();
        prog(0, 100, 25, 1, 1);
        expCount = 5'd1;
        wr(100, 25);
        wr(100, 25);
        chk("repeat ocount", 64'(count), 64'd1);
        chk("repeat ofail", 64'(fail), 64'd0);
        wr(40, 30);
        chk("repeat opass", 64'(pass), 64'd1);

        // Ignore window then unexpected write
        doReset();
        wr(97, 32'hdead);
        wr(96, 1);
        wr(99, 2);
        chk("ignore ofail", 64'(fail), 64'd0);
        wr(200, 7);
        chk("unexp ocause", 64'(cause), 64'd1);
        chk("unexp addr", 64'(failAddr), 64'd200);
        chk("unexp data", 64'(failData), 64'd7);
        wr(100, 25);
        chk("frozen addr", 64'(failAddr), 64'd200);

        // Upper window edge is unexpected
        doReset();
        wr(100, 1);
        chk("win edge ocause", 64'(cause), 64'd1);

        // Count short at end-of-test
        doReset();
        prog(0, 100, 25, 1, 1);
        prog(1, 104, 4096, 1, 1);
        expCount = 5'd3;
        wr(100, 25);
        wr(104, 4096);
        wr(40, 30);
        chk("short ocause", 64'(cause), 64'd3);
        chk("short addr", 64'(failAddr), 64'd40);
        chk("short data", 64'(failData), 64'd30);

        // Uncounted entry and lowest-index priority
        doReset();
        prog(5, 108, 7, 1, 1);
        prog(2, 108, 7, 0, 1);
        wr(108, 7);
        chk("prio mask", 64'(hitMask), 64'h4);
        chk("uncounted ocount", 64'(count), 64'd0);

        // Same-cycle program+write uses the old table; reprogram clears hit bit only
        doReset();
        prog(0, 100, 25, 1, 1);
        wr(100, 25);
        prog(0, 100, 25, 1, 1);
        chk("reprog mask", 64'(hitMask), 64'h0);
        chk("reprog ocount", 64'(count), 64'd1);
        wr(100, 25);
        chk("rehit ocount", 64'(count), 64'd2);
        setProg(0, 100, 25, 1, 0); setWr(100, 25); tick("prog+wr");
        chk("prog+wr ofail", 64'(fail), 64'd0);
        wr(100, 25);
        chk("cleared ocause", 64'(cause), 64'd1);

        // Timeout after TMO RUN cycles, with no capture
        doReset();
        for (int i = 0; i < TMO - 1; i++) tick("idle");
        chk("pre-tmo ofail", 64'(fail), 64'd0);
        tick("idle");
        chk("tmo ocause", 64'(cause), 64'd2);
        chk("tmo addr", 64'(failAddr), 64'd0);
        wr(200, 7);
        chk("tmo frozen", 64'(cause), 64'd2);

        // Write on the timeout cycle wins
        doReset();
        for (int i = 0; i < TMO - 1; i++) tick("idle");
        wr(100, 25);
        chk("race ocause", 64'(cause), 64'd1);
        chk("race addr", 64'(failAddr), 64'd100);

        // Reset from PASS; programming during reset is dropped
        doReset();
        prog(0, 100, 25, 1, 1);
        expCount = 5'd1;
        wr(100, 25);
        wr(40, 30);
        chk("pre-rst opass", 64'(pass), 64'd1);
        setProg(0, 100, 25, 1, 1); rst = 1'b1; tick("reset in pass");
        chk("post-rst opass", 64'(pass), 64'd0);
        chk("post-rst mask", 64'(hitMask), 64'd0);
        wr(100, 25);
        chk("post-rst ocause", 64'(cause), 64'd1);

        // Randomized traffic against the model
        for (int it = 0; it < 25; it++) begin
            doReset();
            expCount = 5'($urandom_range(0, 4));
            k = $urandom_range(1, 5);
            for (int j = 0; j < k; j++)
                prog($urandom_range(0, 15), addrPool[$urandom_range(0, 5)],
                     dataPool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) != 0);
            for (int c = 0; c < 60; c++) begin
                r = $urandom_range(0, 99);
                if (r >= 30 && r < 55) begin
                    k = $urandom_range(0, 15);
                    if (tV[k]) setWr(tA[k], tD[k]);
                    else setWr(addrPool[$urandom_range(0, 5)], dataPool[$urandom_range(0, 5)]);
                end else if (r >= 55 && r < 65) begin
                    setWr(32'($urandom_range(94, 101)), $urandom);
                end else if (r >= 65 && r < 72) begin
                    setWr(40, 30);
                end else if (r >= 72 && r < 76) begin
                    setWr(32'($urandom_range(0, 255)), 32'($urandom_range(0, 31)));
                end
                if (r >= 85 && r < 95) begin
                    setProg($urandom_range(0, 15), addrPool[$urandom_range(0, 5)],
                            dataPool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                            $urandom_range(0, 3) != 0);
                    if (r >= 90) begin
                        k = $urandom_range(0, 15);
                        if (tV[k]) setWr(tA[k], tD[k]);
                    end
                end
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
